scalar_operand_fetch: RTL and testbench

- Operand-fetch / ID-EX pipeline stage directly downstream of the scalar register file.
- Drives the file's read addresses and takes its combinational read data.
- Resolves operands by bypassing from the MEM and WB stages, stalls on unresolved hazards, and holds resolved operands in a valid/ready-handshaked pipeline register for the execute stage.

---
 rtl/scalar_operand_fetch.sv | 113 +++++++++++
 tb/tb_scalar_operand_fetch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scalar_operand_fetch.sv
// Operand fetch / ID-EX register: MEM/WB bypass, load-use and EX-dependency stalls.
// 1-cycle latency; holds its output while out_valid && !out_ready, and in_ready drops on any hazard.
module scalar_operand_fetch #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic              in_use_rs1,
   input  logic              in_use_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_rd_we,
   input  logic              in_is_load,
   output logic [ADDR_W-1:0] rf_rs1,
   output logic [ADDR_W-1:0] rf_rs2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_rd_we,
   output logic              out_is_load,
   output logic              illegal_reg
);

   localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

   logic              bad1, bad2;
   logic              haz1, haz2, hazard;
   logic              load_en;
   logic [DATA_W-1:0] op1, op2;

   assign rf_rs1 = in_rs1;
   assign rf_rs2 = in_rs2;

   assign bad1 = ({1'b0, in_rs1} >= NUM_REGS_W);
   assign bad2 = ({1'b0, in_rs2} >= NUM_REGS_W);

   // MEM outranks WB: it holds the younger write to the same register.
   always_comb begin
      op1 = rf_rdata1;
      if (bad1)
         op1 = '0;
      else if (mem_we && !mem_is_load && mem_rd == in_rs1)
         op1 = mem_data;
      else if (wb_we && wb_rd == in_rs1)
         op1 = wb_data;
   end

   always_comb begin
      op2 = rf_rdata2;
      if (bad2)
         op2 = '0;
      else if (mem_we && !mem_is_load && mem_rd == in_rs2)
         op2 = mem_data;
      else if (wb_we && wb_rd == in_rs2)
         op2 = wb_data;
   end

   // No EX bypass: an EX producer or a load in MEM must drain one more stage.
   assign haz1 = in_use_rs1 &&
                 ((out_valid && out_rd_we && out_rd == in_rs1) ||
                  (mem_we && mem_is_load && mem_rd == in_rs1));
   assign haz2 = in_use_rs2 &&
                 ((out_valid && out_rd_we && out_rd == in_rs2) ||
                  (mem_we && mem_is_load && mem_rd == in_rs2));
   assign hazard = haz1 || haz2;

   assign load_en  = !out_valid || out_ready;
   assign in_ready = load_en && !hazard && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_op1     <= '0;
         out_op2     <= '0;
         out_rd      <= '0;
         out_rd_we   <= 1'b0;
         out_is_load <= 1'b0;
         illegal_reg <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_en) begin
         if (in_valid && !hazard) begin
            out_valid   <= 1'b1;
            out_op1     <= op1;
            out_op2     <= op2;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
            out_is_load <= in_is_load;
            illegal_reg <= (in_use_rs1 && bad1) || (in_use_rs2 && bad2);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_scalar_operand_fetch.sv
// Directed bench for scalar_operand_fetch: hand-computed expectations.
module tb_scalar_operand_fetch;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
   logic              in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
   logic [ADDR_W-1:0] rf_rs1, rf_rs2;
   logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
   logic              mem_we, mem_is_load;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_op1, out_op2;
   logic [ADDR_W-1:0] out_rd;
   logic              out_rd_we, out_is_load, illegal_reg;

   int checks   = 0;
   int failures = 0;

   scalar_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(15)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load), .illegal_reg(illegal_reg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_rs1 = 5'd1; in_rs2 = 5'd2; in_use_rs1 = 1'b1; in_use_rs2 = 1'b1;
      in_rd = 5'd6; in_rd_we = 1'b0; in_is_load = 1'b0;
      rf_rdata1 = 32'h10; rf_rdata2 = 32'h20;
      mem_we = 1'b0; mem_is_load = 1'b0; mem_rd = 5'd0; mem_data = '0;
      wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
      #3;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_op1", out_op1, 0);
      check("reset_illegal", illegal_reg, 0);
      step();
      rst_n = 1'b1;

      // Plain register-file read
      in_valid = 1'b1;
      #1 check("plain_in_ready_pre", in_ready, 1);
      check("rf_rs1_copy", rf_rs1, 1);
      step();
      check("plain_out_valid", out_valid, 1);
      check("plain_op1", out_op1, 32'h10);
      check("plain_op2", out_op2, 32'h20);
      check("plain_in_ready_post", in_ready, 1);

      // WB bypass, then MEM outranks WB
      in_rs1 = 5'd3; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hAAAA;
      step();
      check("wb_bypass_op1", out_op1, 32'hAAAA);
      mem_we = 1'b1; mem_rd = 5'd3; mem_data = 32'hBBBB;
      step();
      check("mem_over_wb_op1", out_op1, 32'hBBBB);
      mem_we = 1'b0; wb_we = 1'b0; in_valid = 1'b0;
      step();

      // ALU producer r5 followed by a dependent: one bubble
      in_valid = 1'b1; in_rs1 = 5'd1; rf_rdata1 = 32'h11; in_rd = 5'd5; in_rd_we = 1'b1;
      step();
      check("alu_prod_rd", out_rd, 5);
      in_rs1 = 5'd5; in_rd = 5'd7; in_rd_we = 1'b0;
      #1 check("alu_dep_stall", in_ready, 0);
      step();
      mem_we = 1'b1; mem_is_load = 1'b0; mem_rd = 5'd5; mem_data = 32'h5555;
      #1 check("alu_bubble_valid", out_valid, 0);
      check("alu_resume_ready", in_ready, 1);
      step();
      check("alu_dep_valid", out_valid, 1);
      check("alu_dep_op1", out_op1, 32'h5555);
      mem_we = 1'b0; in_valid = 1'b0;
      step();

      // Load producer r5 followed by a dependent: two bubbles
      in_valid = 1'b1; in_rs1 = 5'd1; in_rd = 5'd5; in_rd_we = 1'b1; in_is_load = 1'b1;
      step();
      check("load_prod_is_load", out_is_load, 1);
      in_rs1 = 5'd5; in_rd = 5'd7; in_rd_we = 1'b0; in_is_load = 1'b0; rf_rdata1 = 32'h1;
      #1 check("load_stall1", in_ready, 0);
      step();
      mem_we = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd5;
      #1 check("load_bubble1_valid", out_valid, 0);
      check("load_stall2", in_ready, 0);
      step();
      mem_we = 1'b0; mem_is_load = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h7777;
      #1 check("load_bubble2_valid", out_valid, 0);
      check("load_resume_ready", in_ready, 1);
      step();
      check("load_dep_valid", out_valid, 1);
      check("load_dep_op1", out_op1, 32'h7777);
      wb_we = 1'b0;

      // Backpressure: output held for three cycles
      out_ready = 1'b0; in_rs1 = 5'd1; rf_rdata1 = 32'h99; in_rd = 5'd9;
      for (int i = 0; i < 3; i++) begin
         #1 check("bp_in_ready", in_ready, 0);
         step();
         check("bp_valid", out_valid, 1);
         check("bp_op1", out_op1, 32'h7777);
         check("bp_op2", out_op2, 32'h20);
         check("bp_rd", out_rd, 7);
      end
      out_ready = 1'b1;
      step();
      check("bp_release_op1", out_op1, 32'h99);
      check("bp_release_rd", out_rd, 9);

      // Flush kills the held and the incoming instruction
      flush = 1'b1;
      #1 check("flush_in_ready", in_ready, 0);
      step();
      check("flush_out_valid", out_valid, 0);
      flush = 1'b0;

      // Illegal source address, used then unused
      in_rs2 = 5'd20; rf_rdata2 = 32'h1234; in_use_rs2 = 1'b1;
      step();
      check("illegal_op2", out_op2, 0);
      check("illegal_flag", illegal_reg, 1);
      in_use_rs2 = 1'b0; rf_rdata1 = 32'h55;
      step();
      check("illegal_unused_flag", illegal_reg, 0);
      check("pre_reset_op1", out_op1, 32'h55);
      in_valid = 1'b0;

      // Asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1 check("async_rst_valid", out_valid, 0);
      check("async_rst_op1", out_op1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
